dram_burst_engine: RTL

- AXI4 master that moves multi-beat INCR bursts between user streams and the DDR4 controller port.
- Successor to the single-beat DRAM access block, generalised as follows:
  - data/address/ID widths and maximum burst length are parameters;
  - bursts are real multi-beat, with wlast generated internally;
  - write data and read data are backpressured valid/ready streams;
  - requests that would cross a 4 KB boundary are rejected.
- Sits between image/weight producers–consumers and the PS/MIG AXI slave port.

---
 rtl/dram_burst_pkg.sv | 14 +
 rtl/dram_burst_beat_counter.sv | 15 +
 rtl/dram_burst_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_burst_pkg.sv
// dram_burst_pkg: shared FSM states, response codes and burst legality check for dram_burst_engine
package dram_burst_pkg;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   // A burst is legal when it fits the beat limit and ends at or before the next 4 KB page
   function automatic logic burst_is_legal(input logic [11:0] addr, input logic [7:0] len,
                                           input int unsigned bytes_per_beat, input int unsigned max_len);
      int unsigned beats;
      beats = {24'd0, len} + 32'd1;
      return (beats <= max_len) && ({20'd0, addr} + beats * bytes_per_beat <= 32'd4096);
   endfunction
endpackage

// File: rtl/dram_burst_beat_counter.sv
// dram_burst_beat_counter: per-burst beat counter with last-beat flag, cleared on burst start
module dram_burst_beat_counter (
   input  logic       m_axi_aclk,
   input  logic       m_axi_areset,
   input  logic       start,
   input  logic       beat,
   input  logic [7:0] len,
   output logic       last
);
   logic [7:0] count;
   always_ff @(posedge m_axi_aclk)
      if (m_axi_areset || start) count <= '0;
      else if (beat) count <= count + 8'd1;
   assign last = count == len;
endmodule

// File: rtl/dram_burst_engine.sv
// dram_burst_engine: AXI4 master moving multi-beat INCR bursts between user streams and DDR
module dram_burst_engine
   import dram_burst_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 39,
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ID_WIDTH   = 16,
   parameter int MAX_BURST_LEN  = 256
) (
   input  logic                        m_axi_aclk,
   input  logic                        m_axi_areset,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [15:0]                 m_axi_awuser,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [1:0]                  m_axi_bresp,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [15:0]                 m_axi_aruser,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_ADDR_WIDTH-1:0]   wr_cmd_addr,
   input  logic [7:0]                  wr_cmd_len,
   input  logic                        wr_cmd_valid,
   output logic                        wr_cmd_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
   input  logic                        wr_data_valid,
   output logic                        wr_data_ready,
   output logic                        wr_done,
   output logic [1:0]                  wr_resp,
   input  logic [AXI_ADDR_WIDTH-1:0]   rd_cmd_addr,
   input  logic [7:0]                  rd_cmd_len,
   input  logic                        rd_cmd_valid,
   output logic                        rd_cmd_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rd_data,
   output logic                        rd_data_last,
   output logic                        rd_data_valid,
   input  logic                        rd_data_ready,
   output logic                        rd_done,
   output logic [1:0]                  rd_resp
);
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'(BYTES - 1);
   localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));
   wr_state_t w_state, w_next;
   rd_state_t r_state, r_next;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr_al, rd_addr_al;
   logic wr_legal, rd_legal, wr_accept, rd_accept;
   logic aw_done, w_done, w_hs, w_last, aw_fin, w_fin, r_hs, r_last;
   logic [1:0] r_acc, r_max, r_merged;
   logic unused;
   assign unused = ^{m_axi_bid, m_axi_rid};
   assign m_axi_awsize  = AXSIZE;
   assign m_axi_arsize  = AXSIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_arburst = 2'b01;
   assign m_axi_awid    = '0;
   assign m_axi_arid    = '0;
   assign m_axi_awuser  = '0;
   assign m_axi_aruser  = '0;
   // Unaligned addresses are silently rounded down to the bus width
   assign wr_addr_al = wr_cmd_addr & ~LOW_MASK;
   assign rd_addr_al = rd_cmd_addr & ~LOW_MASK;
   assign wr_legal = burst_is_legal(wr_addr_al[11:0], wr_cmd_len, BYTES, MAX_BURST_LEN);
   assign rd_legal = burst_is_legal(rd_addr_al[11:0], rd_cmd_len, BYTES, MAX_BURST_LEN);
   assign wr_cmd_ready  = (w_state == W_IDLE) && !wr_done;
   assign wr_accept     = wr_cmd_valid && wr_cmd_ready;
   assign m_axi_wvalid  = (w_state == W_XFER) && !w_done && wr_data_valid;
   assign wr_data_ready = (w_state == W_XFER) && !w_done && m_axi_wready;
   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = w_last;
   assign m_axi_bready  = w_state == W_RESP;
   assign w_hs   = m_axi_wvalid && m_axi_wready;
   assign aw_fin = aw_done || (m_axi_awvalid && m_axi_awready);
   assign w_fin  = w_done || (w_hs && w_last);
   dram_burst_beat_counter u_wr_cnt (
      .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
      .start(wr_accept), .beat(w_hs), .len(m_axi_awlen), .last(w_last)
   );
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (wr_accept && wr_legal) w_next = W_XFER;
         W_XFER:  if (aw_fin && w_fin) w_next = W_RESP;
         W_RESP:  if (m_axi_bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         w_state <= W_IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr <= '0;
         m_axi_awlen <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
         wr_done <= 1'b0;
         wr_resp <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         wr_done <= 1'b0;
         if (wr_accept) begin
            m_axi_awaddr <= wr_addr_al;
            m_axi_awlen <= wr_cmd_len;
            m_axi_awvalid <= wr_legal;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            if (!wr_legal) begin
               wr_done <= 1'b1;
               wr_resp <= RESP_SLVERR;
            end
         end
         if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            aw_done <= 1'b1;
         end
         if (w_hs && w_last) w_done <= 1'b1;
         if (m_axi_bready && m_axi_bvalid) begin
            wr_done <= 1'b1;
            wr_resp <= m_axi_bresp;
         end
      end
   end
   assign rd_cmd_ready  = (r_state == R_IDLE) && !rd_done;
   assign rd_accept     = rd_cmd_valid && rd_cmd_ready;
   assign m_axi_rready  = (r_state == R_DATA) && rd_data_ready;
   assign rd_data_valid = (r_state == R_DATA) && m_axi_rvalid;
   assign rd_data       = m_axi_rdata;
   assign rd_data_last  = m_axi_rlast;
   assign r_hs = m_axi_rvalid && m_axi_rready;
   // Burst-length disagreement between our count and the slave's rlast overrides any response
   assign r_max    = (m_axi_rresp > r_acc) ? m_axi_rresp : r_acc;
   assign r_merged = (r_last != m_axi_rlast) ? RESP_SLVERR : r_max;
   dram_burst_beat_counter u_rd_cnt (
      .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
      .start(rd_accept), .beat(r_hs), .len(m_axi_arlen), .last(r_last)
   );
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (rd_accept && rd_legal) r_next = R_ADDR;
         R_ADDR:  if (m_axi_arready) r_next = R_DATA;
         R_DATA:  if (r_hs && m_axi_rlast) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         r_state <= R_IDLE;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr <= '0;
         m_axi_arlen <= '0;
         r_acc <= RESP_OKAY;
         rd_done <= 1'b0;
         rd_resp <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         rd_done <= 1'b0;
         if (rd_accept) begin
            m_axi_araddr <= rd_addr_al;
            m_axi_arlen <= rd_cmd_len;
            m_axi_arvalid <= rd_legal;
            r_acc <= RESP_OKAY;
            if (!rd_legal) begin
               rd_done <= 1'b1;
               rd_resp <= RESP_SLVERR;
            end
         end
         if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
         if (r_hs) begin
            r_acc <= r_merged;
            if (m_axi_rlast) begin
               rd_done <= 1'b1;
               rd_resp <= r_merged;
            end
         end
      end
   end
endmodule
